// File: rtl/challenge_poly_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dilithium_pkg
// Purpose  : Shared constants, types and helpers for the challenge polynomial
//            read-back path (modulus, tau per ML-DSA level, coefficient codes).
// Revision : 1.0 - initial release
// ============================================================================
package dilithium_pkg;

  localparam int N      = 256;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int IDX_W  = 8;
  localparam int WT_W   = 7;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

  localparam logic [DATA_W-1:0] Q         = 24'd8380416 + 24'd1;
  localparam logic [DATA_W-1:0] Q_MINUS_1 = Q - 24'd1;

  localparam logic [WT_W-1:0] TAU_44 = 7'd39;
  localparam logic [WT_W-1:0] TAU_65 = 7'd49;
  localparam logic [WT_W-1:0] TAU_87 = 7'd60;

  localparam logic [1:0] LEVEL_44   = 2'b00;
  localparam logic [1:0] LEVEL_65   = 2'b01;
  localparam logic [1:0] LEVEL_87   = 2'b10;
  localparam logic [1:0] LEVEL_RSVD = 2'b11;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b11;
  localparam logic [1:0] CODE_BAD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // One FIFO entry: coefficient index on top, decoded value below.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Ternary code to value mod q; the invalid code reads as zero.
  function automatic logic [DATA_W-1:0] decode_coeff(input logic [1:0] code);
    case (code)
      CODE_ZERO: return '0;
      CODE_POS:  return 24'd1;
      CODE_NEG:  return Q_MINUS_1;
      default:   return '0;
    endcase
  endfunction

  // Expected Hamming weight of c for a level; reserved level never matches.
  function automatic logic [WT_W-1:0] tau_of(input logic [1:0] level);
    case (level)
      LEVEL_44: return TAU_44;
      LEVEL_65: return TAU_65;
      LEVEL_87: return TAU_87;
      default:  return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/challenge_poly_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : challenge_poly_reader_if
// Purpose  : Control, memory-port and coefficient-stream signals of the
//            challenge polynomial reader, with DUT (slave) and driver
//            (master) views.
// Revision : 1.0 - initial release
// ============================================================================
interface challenge_poly_reader_if;
  import dilithium_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        ml_dsa_level;
  logic [ADDR_W-1:0] mem_A;
  logic              mem_WEB;
  logic              mem_CEB;
  logic [DATA_W-1:0] mem_Q;
  logic              coeff_valid;
  logic              coeff_ready;
  logic [DATA_W-1:0] coeff_data;
  logic [IDX_W-1:0]  coeff_index;
  logic              busy;
  logic              done;
  logic              weight_ok;
  logic              code_err;

  modport slave (
    input  start, base_addr, ml_dsa_level, mem_Q, coeff_ready,
    output mem_A, mem_WEB, mem_CEB, coeff_valid, coeff_data, coeff_index,
           busy, done, weight_ok, code_err
  );

  modport master (
    output start, base_addr, ml_dsa_level, mem_Q, coeff_ready,
    input  mem_A, mem_WEB, mem_CEB, coeff_valid, coeff_data, coeff_index,
           busy, done, weight_ok, code_err
  );

endinterface
`default_nettype wire

// File: rtl/challenge_poly_reader_coeff_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : coeff_skid_fifo
// Purpose  : Two-entry FIFO absorbing the one-cycle memory latency so the
//            output stream can stall without losing a returning read word.
// Revision : 1.0 - initial release
// ============================================================================
module coeff_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage and pointers; a push into a full FIFO is only
  // taken when the same cycle frees the head.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = din;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      slot_q    <= slot_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign dout  = slot_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/challenge_poly_reader.sv
`default_nettype none
// ============================================================================
// Module   : challenge_poly_reader
// Purpose  : Reads the 256 ternary coefficients of c from memory, decodes
//            them mod q, streams them with valid/ready and checks the
//            Hamming weight against tau of the selected ML-DSA level.
// Revision : 1.0 - initial release
// ============================================================================
module challenge_poly_reader
  import dilithium_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  challenge_poly_reader_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        level_q, level_d;
  logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0]  out_cnt_q, out_cnt_d;
  logic [WT_W-1:0]   weight_q, weight_d;
  logic              code_err_q, code_err_d;
  logic              pend_q, pend_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              weight_ok_q, weight_ok_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic [2:0]        occ_after;
  logic              issue;
  logic [1:0]        ret_code;
  beat_t             fifo_din, fifo_dout;
  logic              unused_bits;

  coeff_skid_fifo #(.WIDTH($bits(beat_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend_q),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue a read only if the FIFO can hold it once the in-flight word lands,
  // crediting a pop happening this cycle so full rate is sustained.
  always_comb begin
    fifo_pop  = bus.coeff_ready && !fifo_empty;
    occ_after = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, pend_q};
    issue     = (state_q == ST_ISSUE) && (occ_after < 3'd2);
    ret_code  = bus.mem_Q[1:0];
    fifo_din  = '{idx: pend_idx_q, data: decode_coeff(ret_code)};
  end

  // Run sequencing, counters and status.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    level_d     = level_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    weight_d    = weight_q;
    code_err_d  = code_err_q;
    pend_d      = issue;
    pend_idx_d  = issue ? rd_cnt_q : pend_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    weight_ok_d = weight_ok_q;

    if (pend_q) begin
      if ((ret_code == CODE_POS) || (ret_code == CODE_NEG)) begin
        weight_d = weight_q + 7'd1;
      end
      if (ret_code == CODE_BAD) begin
        code_err_d = 1'b1;
      end
    end
    if (fifo_pop) begin
      out_cnt_d = out_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_ISSUE;
          base_d      = bus.base_addr;
          level_d     = bus.ml_dsa_level;
          rd_cnt_d    = '0;
          out_cnt_d   = '0;
          weight_d    = '0;
          code_err_d  = 1'b0;
          weight_ok_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 8'd1;
          if (rd_cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && (out_cnt_q == LAST_IDX)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        weight_ok_d = (level_q != LEVEL_RSVD) && (weight_q == tau_of(level_q))
                      && !code_err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      level_q     <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      weight_q    <= '0;
      code_err_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      weight_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      level_q     <= level_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      weight_q    <= weight_d;
      code_err_q  <= code_err_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      weight_ok_q <= weight_ok_d;
    end
  end

  assign bus.mem_A       = issue ? (base_q + {{(ADDR_W-IDX_W){1'b0}}, rd_cnt_q}) : '0;
  assign bus.mem_CEB     = !issue;
  assign bus.mem_WEB     = 1'b1;
  assign bus.coeff_valid = !fifo_empty;
  assign bus.coeff_data  = fifo_dout.data;
  assign bus.coeff_index = fifo_dout.idx;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.weight_ok   = weight_ok_q;
  assign bus.code_err    = code_err_q;

  // Upper memory bits carry no coefficient information.
  assign unused_bits = ^{bus.mem_Q[DATA_W-1:2], fifo_full};

endmodule
`default_nettype wire

// File: tb/tb_challenge_poly_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_challenge_poly_reader
// Purpose  : Self-checking bench: memory model, per-run expected beat list
//            derived from memory contents, and a per-cycle output check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_challenge_poly_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  challenge_poly_reader_if bus();

  challenge_poly_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous-read memory, one cycle latency.
  logic [23:0] mem [0:65535];
  always @(posedge clk) begin
    if (!bus.mem_CEB) bus.mem_Q <= mem[bus.mem_A];
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          active = 1'b0;
  bit          fixed = 1'b0;
  bit          pin_en = 1'b0;
  logic [15:0] run_base;
  logic [23:0] exp_data [256];
  int          first_err;
  bit          exp_wok;
  int          beat_cnt, issue_cnt, done_seen;
  bit          stall_q;
  logic [23:0] hold_data;
  logic [7:0]  hold_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream from memory contents: values, first bad code, weight verdict.
  task automatic build_model(input logic [15:0] base, input logic [1:0] lvl);
    int nz;
    int tau;
    logic [15:0] a;
    logic [1:0]  code;
    nz = 0;
    first_err = 256;
    for (int i = 0; i < 256; i++) begin
      a = base + 16'(i);
      code = mem[a][1:0];
      if (code == 2'b01) begin exp_data[i] = 24'd1; nz++; end
      else if (code == 2'b11) begin exp_data[i] = 24'd8380416; nz++; end
      else exp_data[i] = 24'd0;
      if (code == 2'b10 && first_err == 256) first_err = i;
    end
    case (lvl)
      2'b00: tau = 39;
      2'b01: tau = 49;
      2'b10: tau = 60;
      default: tau = -1;
    endcase
    exp_wok = (tau >= 0) && (nz == tau) && (first_err == 256);
  endtask

  // 39 nonzero codes at every 6th index below 234; upper bits are noise.
  task automatic fill_t1(input logic [15:0] base);
    logic [1:0] code;
    for (int i = 0; i < 256; i++) begin
      if (i < 234 && i % 6 == 0) code = (i % 12 == 0) ? 2'b01 : 2'b11;
      else code = 2'b00;
      mem[base + 16'(i)] = {22'($urandom), code};
    end
  endtask

  task automatic fill_random(input logic [15:0] base, input int nz);
    int pos [256];
    int j, t;
    for (int i = 0; i < 256; i++) pos[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = pos[i]; pos[i] = pos[j]; pos[j] = t;
    end
    for (int i = 0; i < 256; i++) mem[base + 16'(i)] = {22'($urandom), 2'b00};
    for (int i = 0; i < nz; i++)
      mem[base + 16'(pos[i])] = {22'($urandom), ($urandom_range(1, 0) != 0) ? 2'b01 : 2'b11};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_A"},       32'(bus.mem_A), 0);
    chk({tag, "_mem_CEB"},     32'(bus.mem_CEB), 1);
    chk({tag, "_mem_WEB"},     32'(bus.mem_WEB), 1);
    chk({tag, "_coeff_valid"}, 32'(bus.coeff_valid), 0);
    chk({tag, "_coeff_data"},  32'(bus.coeff_data), 0);
    chk({tag, "_coeff_index"}, 32'(bus.coeff_index), 0);
    chk({tag, "_busy"},        32'(bus.busy), 0);
    chk({tag, "_done"},        32'(bus.done), 0);
    chk({tag, "_weight_ok"},   32'(bus.weight_ok), 0);
    chk({tag, "_code_err"},    32'(bus.code_err), 0);
  endtask

  // Per-cycle comparison of DUT outputs against the expected run.
  task automatic compare();
    logic [15:0] ea;
    chk("mem_web_high", 32'(bus.mem_WEB), 1);
    if (done_seen > 0) begin
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_ceb", 32'(bus.mem_CEB), 1);
      chk("done_pulse_len", 32'(bus.done), 0);
    end
    if (!bus.mem_CEB) begin
      ea = run_base + 16'(issue_cnt);
      chk("mem_addr", 32'(bus.mem_A), 32'(ea));
      issue_cnt++;
    end
    if (fixed && cyc == start_cyc + 1) chk("valid_before_lat", 32'(bus.coeff_valid), 0);
    if (fixed && cyc == start_cyc + 2) chk("valid_at_lat", 32'(bus.coeff_valid), 1);
    if (fixed && first_err < 256) begin
      if (cyc == start_cyc + 1 + first_err) chk("code_err_not_yet", 32'(bus.code_err), 0);
      if (cyc == start_cyc + 2 + first_err) chk("code_err_rise", 32'(bus.code_err), 1);
    end
    if (cyc >= start_cyc) begin
      if (bus.coeff_valid && first_err <= beat_cnt) chk("code_err_sticky", 32'(bus.code_err), 1);
      if (first_err > beat_cnt + 1) chk("code_err_clear", 32'(bus.code_err), 0);
      if (done_seen == 0 && !bus.done) chk("busy_in_run", 32'(bus.busy), 1);
    end
    if (stall_q) begin
      chk("stall_valid", 32'(bus.coeff_valid), 1);
      chk("stall_data", 32'(bus.coeff_data), 32'(hold_data));
      chk("stall_index", 32'(bus.coeff_index), 32'(hold_idx));
    end
    if (bus.done) begin
      chk("done_beats", 32'(beat_cnt), 256);
      chk("done_issues", 32'(issue_cnt), 256);
      chk("done_busy", 32'(bus.busy), 0);
      chk("done_weight_ok", 32'(bus.weight_ok), 32'(exp_wok));
      chk("done_code_err", 32'(bus.code_err), 32'(first_err < 256));
      if (fixed) chk("done_cycle", 32'(cyc - start_cyc), 259);
      if (pin_en) chk("pin_weight_ok_44", 32'(bus.weight_ok), 1);
      done_seen++;
    end
    if (bus.coeff_valid && bus.coeff_ready) begin
      if (beat_cnt < 256) begin
        chk("beat_data", 32'(bus.coeff_data), 32'(exp_data[beat_cnt]));
        chk("beat_index", 32'(bus.coeff_index), 32'(beat_cnt));
        if (pin_en && beat_cnt == 0) chk("pin_beat0", 32'(bus.coeff_data), 32'd1);
        if (pin_en && beat_cnt == 1) chk("pin_beat1", 32'(bus.coeff_data), 32'd0);
        if (pin_en && beat_cnt == 6) chk("pin_beat6", 32'(bus.coeff_data), 32'd8380416);
      end else begin
        chk("extra_beat", 32'(beat_cnt), 255);
      end
      beat_cnt++;
    end
    stall_q   = bus.coeff_valid && !bus.coeff_ready;
    hold_data = bus.coeff_data;
    hold_idx  = bus.coeff_index;
  endtask

  // One clock: drive inputs, compare at the falling edge, advance past the rise.
  task automatic step(input logic rdy, input logic st, input logic [15:0] ba);
    bus.coeff_ready = rdy;
    bus.start       = st;
    bus.base_addr   = ba;
    @(negedge clk);
    if (active) compare();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic begin_run(input logic [15:0] base, input logic [1:0] lvl, input bit fx);
    build_model(base, lvl);
    run_base  = base;
    beat_cnt  = 0;
    issue_cnt = 0;
    done_seen = 0;
    stall_q   = 1'b0;
    fixed     = fx;
    active    = 1'b1;
    bus.ml_dsa_level = lvl;
    start_cyc = cyc + 1;
    step(1'b1, 1'b1, base);
    bus.ml_dsa_level = ~lvl;
  endtask

  task automatic run(input logic [15:0] base, input logic [1:0] lvl, input bit rnd,
                     input bit fx, input int dup_at);
    int n;
    logic rdy;
    begin_run(base, lvl, fx);
    n = 0;
    while (done_seen == 0 && n < 3000) begin
      rdy = rnd ? ($urandom_range(99, 0) >= 30) : 1'b1;
      step(rdy, (n == dup_at), (n == dup_at) ? base + 16'h0100 : base ^ 16'h5555);
      n++;
    end
    if (done_seen == 0) chk("done_timeout", 0, 1);
    repeat (4) step(1'b1, 1'b0, 16'h0000);
    chk("done_once", 32'(done_seen), 1);
    active = 1'b0;
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.base_addr    = '0;
    bus.ml_dsa_level = '0;
    bus.coeff_ready  = 1'b0;
    first_err        = 256;
    repeat (3) step(1'b0, 1'b0, 16'h0000);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) step(1'b1, 1'b0, 16'h0000);
    check_reset_outputs("idle");

    // Nominal ML-DSA-44 run at full rate with literal pins.
    fill_t1(16'h1000);
    pin_en = 1'b1;
    run(16'h1000, 2'b00, 1'b0, 1'b1, -1);
    pin_en = 1'b0;

    // Same data, ML-DSA-65: weight mismatch; start during FIN is ignored.
    run(16'h1000, 2'b01, 1'b0, 1'b1, 258);

    // Random data with backpressure, ML-DSA-87; start while busy ignored.
    fill_random(16'h2345, 60);
    run(16'h2345, 2'b10, 1'b1, 1'b0, 100);

    // Invalid code at index 100.
    fill_random(16'h3000, 39);
    mem[16'h3064] = 24'h000002;
    run(16'h3000, 2'b00, 1'b0, 1'b1, -1);

    // Address wrap with backpressure; new start clears code_err.
    fill_t1(16'hFFF0);
    run(16'hFFF0, 2'b00, 1'b1, 1'b0, -1);

    // Reserved level never passes.
    run(16'hFFF0, 2'b11, 1'b0, 1'b1, -1);

    // Reset in the middle of a run.
    fill_t1(16'h0400);
    begin_run(16'h0400, 2'b00, 1'b0);
    n = 0;
    while (beat_cnt < 50 && n < 500) begin
      step(1'b1, 1'b0, 16'h0000);
      n++;
    end
    if (beat_cnt < 50) chk("reset_wait_timeout", 32'(beat_cnt), 50);
    rst_n  = 1'b0;
    active = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) step(1'b1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    repeat (3) begin
      step(1'b1, 1'b0, 16'h0000);
      chk("post_abort_done", 32'(bus.done), 0);
      chk("post_abort_busy", 32'(bus.busy), 0);
    end
    run(16'h0400, 2'b00, 1'b1, 1'b0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
